// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub/accumulate datapath.
//   mode_e     : operation select encoding carried on the 2-bit mode port
//   is_acc_op  : true for operations that write the internal accumulator
package addsub_pkg;

    localparam int unsigned ModeWidth = 2;

    typedef enum logic [ModeWidth-1:0] {
        ModeAdd  = 2'd0,
        ModeSub  = 2'd1,
        ModeAcc  = 2'd2,
        ModeLoad = 2'd3
    } mode_e;

    function automatic logic is_acc_op(input mode_e mode);
        return (mode == ModeAcc) || (mode == ModeLoad);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data holding register of a valid/ready pipeline.
//   clk, rst : clock, asynchronous active-high reset (clears valid and data)
//   load_i   : stage advances this cycle (captures valid_i, and data_i if valid)
//   valid_i  : upstream valid presented to this stage
//   data_i   : upstream payload
//   valid_o  : stage holds a valid item
//   data_o   : held payload, stable while load_i is low
module pipe_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = valid_i;
            // Bubbles leave the payload untouched to avoid needless toggling.
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/addsub_acc.sv
// Two-stage add / subtract / accumulate / load unit with valid/ready handshakes.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready combinational from out_ready)
//   mode                : 0 ADD, 1 SUB, 2 ACC, 3 LOAD
//   a_in, b_in          : unsigned operands (b_in unused by ACC/LOAD)
//   out_valid, out_ready: result handshake
//   sum_o               : WIDTH+1 bit result
//   ovf_o               : borrow (SUB) or carry (ACC) flag, qualified by out_valid
// S1 holds the request, arithmetic sits between S1 and S2, S2 holds the result.
module addsub_acc
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum_o,
    output logic             ovf_o
);

    localparam int unsigned S1Width = ModeWidth + 2 * WIDTH;
    localparam int unsigned S2Width = WIDTH + 2;

    logic               s1_valid;
    logic [S1Width-1:0] s1_data;
    logic [S2Width-1:0] s2_data;
    logic               s2_advance;

    mode_e              s1_mode;
    logic [WIDTH-1:0]   s1_a, s1_b;

    logic [WIDTH:0]     res_sum;
    logic               res_ovf;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH+1:0]   acc_ext;
    logic [WIDTH:0]     acc_d, acc_q;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    pipe_stage #(
        .Width (S1Width)
    ) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (in_ready),
        .valid_i (in_valid),
        .data_i  ({mode, a_in, b_in}),
        .valid_o (s1_valid),
        .data_o  (s1_data)
    );

    assign s1_mode = mode_e'(s1_data[S1Width-1 -: ModeWidth]);
    assign s1_a    = s1_data[2*WIDTH-1 -: WIDTH];
    assign s1_b    = s1_data[WIDTH-1:0];

    // Extra top bit exposes the carry out of bit WIDTH.
    assign acc_ext = {1'b0, acc_q} + {2'b00, s1_a};

    always_comb begin
        res_sum  = '0;
        res_ovf  = 1'b0;
        acc_next = acc_q;
        unique case (s1_mode)
            ModeAdd: begin
                res_sum = {1'b0, s1_a} + {1'b0, s1_b};
            end
            ModeSub: begin
                res_sum = {1'b0, s1_a} - {1'b0, s1_b};
                res_ovf = s1_a < s1_b;
            end
            ModeAcc: begin
                res_ovf  = acc_ext[WIDTH+1];
                acc_next = ((SAT != 0) && acc_ext[WIDTH+1]) ? '1 : acc_ext[WIDTH:0];
                res_sum  = acc_next;
            end
            ModeLoad: begin
                acc_next = {1'b0, s1_a};
                res_sum  = acc_next;
            end
            default: ;
        endcase
    end

    // The accumulator commits in the same cycle its op enters S2, so the next
    // op in S1 already sees the updated value (no bubble between ACC ops).
    always_comb begin
        acc_d = acc_q;
        if (s1_valid && s2_advance && is_acc_op(s1_mode)) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    pipe_stage #(
        .Width (S2Width)
    ) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (s2_advance),
        .valid_i (s1_valid),
        .data_i  ({res_ovf, res_sum}),
        .valid_o (out_valid),
        .data_o  (s2_data)
    );

    assign ovf_o = s2_data[S2Width-1];
    assign sum_o = s2_data[WIDTH:0];

endmodule

// File: tb/tb_addsub_acc.sv
// Bench for addsub_acc: wrapping (SAT=0) and saturating (SAT=1) instances
// driven in lockstep, checked against a queue-based arithmetic model.
module tb_addsub_acc;
    import addsub_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned MOD = 1 << (W + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [1:0]   mode;
    logic [W-1:0] a_in, b_in;
    logic         in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [W:0]   sum0, sum1;

    addsub_acc #(.WIDTH(W), .SAT(0)) u_dut_wrap (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready0),
        .mode (mode), .a_in (a_in), .b_in (b_in), .out_valid (out_valid0),
        .out_ready (out_ready), .sum_o (sum0), .ovf_o (ovf0)
    );

    addsub_acc #(.WIDTH(W), .SAT(1)) u_dut_sat (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready1),
        .mode (mode), .a_in (a_in), .b_in (b_in), .out_valid (out_valid1),
        .out_ready (out_ready), .sum_o (sum1), .ovf_o (ovf1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sum0;
        bit          ovf0;
        int unsigned sum1;
        bit          ovf1;
    } res_t;

    res_t        exp_q[$];
    res_t        got_q[$];
    int unsigned acc_wrap, acc_sat;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          in_fire;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model(input int unsigned md, input int unsigned a,
                                  input int unsigned b, input bit sat,
                                  inout int unsigned acc, output int unsigned sum,
                                  output bit ovf);
        int unsigned t;
        sum = 0;
        ovf = 1'b0;
        case (md)
            0: sum = a + b;
            1: begin
                sum = (a + MOD - b) % MOD;
                ovf = a < b;
            end
            2: begin
                t   = acc + a;
                ovf = t >= MOD;
                acc = (sat && ovf) ? MOD - 1 : t % MOD;
                sum = acc;
            end
            default: begin
                acc = a;
                sum = a;
            end
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later, and account
    // for the transfers that the next rising edge will perform.
    task automatic step(input bit vld, input logic [1:0] md, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit ordy);
        res_t e, g;
        @(negedge clk);
        in_valid  = vld;
        mode      = md;
        a_in      = a;
        b_in      = b;
        out_ready = ordy;
        #1;
        check("in_ready_sat_vs_wrap", in_ready1, in_ready0);
        check("out_valid_sat_vs_wrap", out_valid1, out_valid0);
        if (out_valid0 && out_ready) begin
            g.sum0 = sum0; g.ovf0 = ovf0; g.sum1 = sum1; g.ovf1 = ovf1;
            got_q.push_back(g);
            if (exp_q.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sum_wrap", sum0, e.sum0);
                check("ovf_wrap", ovf0, e.ovf0);
                check("sum_sat", sum1, e.sum1);
                check("ovf_sat", ovf1, e.ovf1);
            end
        end
        in_fire = in_valid && in_ready0;
        if (in_fire) begin
            model(md, a, b, 1'b0, acc_wrap, e.sum0, e.ovf0);
            model(md, a, b, 1'b1, acc_sat, e.sum1, e.ovf1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid0); i++) begin
            step(1'b0, 2'd0, '0, '0, 1'b1);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_got(input int idx, input string tag, input int unsigned s0,
                             input bit o0, input int unsigned s1, input bit o1);
        if (got_q.size() <= idx) begin
            check({tag, "_missing"}, got_q.size(), idx + 1);
        end else begin
            check({tag, "_sum_wrap"}, got_q[idx].sum0, s0);
            check({tag, "_ovf_wrap"}, got_q[idx].ovf0, o0);
            check({tag, "_sum_sat"}, got_q[idx].sum1, s1);
            check({tag, "_ovf_sat"}, got_q[idx].ovf1, o1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = '0; a_in = '0; b_in = '0;
        acc_wrap = 0; acc_sat = 0;
        #1;
        check("rst_out_valid", out_valid0, 0);
        check("rst_sum", sum0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_in_ready", in_ready0, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD 255+255 and its two-cycle latency.
        got_q.delete();
        step(1'b1, ModeAdd, 8'd255, 8'd255, 1'b1);
        step(1'b0, ModeAdd, '0, '0, 1'b1);
        check("add_lat1_valid", out_valid0, 0);
        step(1'b0, ModeAdd, '0, '0, 1'b1);
        check("add_lat2_valid", out_valid0, 1);
        drain();
        check_got(0, "add_max", 510, 0, 510, 0);

        // SUB with and without borrow.
        got_q.delete();
        step(1'b1, ModeSub, 8'd3, 8'd5, 1'b1);
        step(1'b1, ModeSub, 8'd5, 8'd3, 1'b1);
        drain();
        check_got(0, "sub_borrow", 9'h1FE, 1, 9'h1FE, 1);
        check_got(1, "sub_plain", 2, 0, 2, 0);

        // LOAD then back-to-back ACCs, overflowing on the last.
        got_q.delete();
        step(1'b1, ModeLoad, 8'd250, 8'd99, 1'b1);
        step(1'b1, ModeAcc, 8'd200, 8'd99, 1'b1);
        step(1'b1, ModeAcc, 8'd100, 8'd99, 1'b1);
        drain();
        check_got(0, "load", 250, 0, 250, 0);
        check_got(1, "acc1", 450, 0, 450, 0);
        check_got(2, "acc2", 38, 1, 511, 1);

        // Consumer stall with continuous requests.
        got_q.delete();
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ModeAdd, W'(i + 1), 8'd1, 1'b0);
            if (in_fire) n_acc++;
            if (i >= 2) begin
                check("stall_in_ready", in_ready0, 0);
                check("stall_out_valid", out_valid0, 1);
                if (exp_q.size() != 0) check("stall_sum_hold", sum0, exp_q[0].sum0);
            end
        end
        check("stall_accepted", n_acc, 2);
        drain();
        check("stall_outputs", got_q.size(), 2);
        check_got(0, "stall_first", 2, 0, 2, 0);
        check_got(1, "stall_second", 3, 0, 3, 0);

        // Reset with two ops in flight.
        got_q.delete();
        step(1'b1, ModeAcc, 8'd10, 8'd0, 1'b1);
        step(1'b1, ModeAcc, 8'd20, 8'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_sum", sum0, 0);
        check("midrst_ovf", ovf0, 0);
        exp_q.delete();
        got_q.delete();
        acc_wrap = 0; acc_sat = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, ModeAcc, 8'd7, 8'd0, 1'b1);
        check("postrst_in_ready", in_ready0, 1);
        drain();
        check_got(0, "postrst_acc", 7, 0, 7, 0);

        // Random traffic with random backpressure.
        for (int n = 0; n < 1000; ) begin
            bit          v;
            logic [1:0]  md;
            v  = ($urandom_range(0, 3) != 0);
            md = 2'($urandom_range(0, 3));
            step(v, md, W'($urandom), W'($urandom), ($urandom_range(0, 2) != 0));
            if (in_fire) n++;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
